// File: rtl/mlaccel_pkg.sv
// Shared types and constants for the mlaccel QPI front end and command decoder.
package mlaccel_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        HI_NIB,
        LO_NIB
    } phy_state_e;

    localparam logic [7:0] OP_WRITE  = 8'h21;
    localparam logic [7:0] OP_READ   = 8'h22;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/mlaccel_sync.sv
// N-stage flip-flop synchroniser for one asynchronous pad input; latency STAGES clocks, no flow control.
module mlaccel_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // No reset: the chain flushes itself while the block is held in reset.
    always_ff @(posedge clock) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mlaccel_qpi_phy.sv
// QPI slave PHY: DDR pin nibbles to decoder bytes, rx_valid SYNC_STAGES+1 clocks after the pin edge.
// Receive has no backpressure; transmit takes one byte via tx_valid/tx_ready, FILL_BYTE on underflow.
module mlaccel_qpi_phy #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = mlaccel_pkg::FILL_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       qpi_csb,
    input  logic       qpi_clk,
    input  logic [3:0] qpi_di,
    output logic [3:0] qpi_do,
    output logic       qpi_oe,
    output logic       rx_start,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_end,
    input  logic       tx_en,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       err
);
    import mlaccel_pkg::*;

    logic       csb_s;
    logic       clk_s;
    logic [3:0] di_s;

    // Identical chains on every pin keep csb, clk and data skew-aligned.
    mlaccel_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (.clock(clock), .d_i(qpi_csb), .q_o(csb_s));
    mlaccel_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (.clock(clock), .d_i(qpi_clk), .q_o(clk_s));

    for (genvar i = 0; i < 4; i++) begin : g_di
        mlaccel_sync #(.STAGES(SYNC_STAGES)) u_sync_di (.clock(clock), .d_i(qpi_di[i]), .q_o(di_s[i]));
    end

    phy_state_e state_q;
    logic       clk_q;
    logic [3:0] nib_hi_q;
    logic [3:0] lo_nib_q;
    logic [7:0] hold_q;
    logic       hold_full_q;
    logic       first_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_start_q;
    logic       rx_end_q;
    logic       err_q;
    logic [3:0] do_q;
    logic       oe_q;

    logic clk_rise;
    logic clk_fall;
    logic in_txn;

    assign clk_rise = clk_s & ~clk_q;
    assign clk_fall = ~clk_s & clk_q;
    assign in_txn   = (state_q == HI_NIB) || (state_q == LO_NIB);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            clk_q       <= 1'b0;
            nib_hi_q    <= 4'h0;
            lo_nib_q    <= 4'h0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_start_q  <= 1'b0;
            rx_end_q    <= 1'b0;
            err_q       <= 1'b0;
            do_q        <= 4'h0;
            oe_q        <= 1'b0;
        end else begin
            clk_q      <= clk_s;
            oe_q       <= tx_en & ~csb_s;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            rx_end_q   <= 1'b0;

            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            // Deselect wins over any clk edge; a byte left unsent is dropped with the transaction.
            if (in_txn && csb_s) begin
                state_q     <= IDLE;
                rx_end_q    <= 1'b1;
                hold_full_q <= 1'b0;
                if (state_q == LO_NIB) begin
                    err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    WAIT_IDLE: begin
                        if (csb_s) begin
                            state_q <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (!csb_s) begin
                            state_q <= HI_NIB;
                            first_q <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                    HI_NIB: begin
                        if (clk_fall) begin
                            nib_hi_q <= di_s;
                            state_q  <= LO_NIB;
                            if (tx_en) begin
                                if (hold_full_q) begin
                                    do_q        <= hold_q[7:4];
                                    lo_nib_q    <= hold_q[3:0];
                                    hold_full_q <= 1'b0;
                                end else begin
                                    do_q     <= FILL_BYTE[7:4];
                                    lo_nib_q <= FILL_BYTE[3:0];
                                    err_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    LO_NIB: begin
                        if (clk_rise) begin
                            rx_data_q  <= {nib_hi_q, di_s};
                            rx_valid_q <= 1'b1;
                            rx_start_q <= first_q;
                            first_q    <= 1'b0;
                            state_q    <= HI_NIB;
                            if (tx_en) begin
                                do_q <= lo_nib_q;
                            end
                        end
                    end
                    default: state_q <= WAIT_IDLE;
                endcase
            end
        end
    end

    assign qpi_do   = do_q;
    assign qpi_oe   = oe_q;
    assign rx_start = rx_start_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_end   = rx_end_q;
    assign tx_ready = ~hold_full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mlaccel_qpi_phy.sv
// Directed bench: host pin model plus decoder model, scoreboard queues for received and read-back bytes.
module tb_mlaccel_qpi_phy;
    import mlaccel_pkg::*;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       qpi_csb  = 1'b1;
    logic       qpi_clk  = 1'b1;
    logic [3:0] qpi_di   = 4'h0;
    logic       tx_en    = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic [3:0] qpi_do;
    logic       qpi_oe;
    logic       rx_start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_end;
    logic       tx_ready;
    logic       err;

    mlaccel_qpi_phy dut (
        .clock(clock), .reset(reset), .qpi_csb(qpi_csb), .qpi_clk(qpi_clk), .qpi_di(qpi_di),
        .qpi_do(qpi_do), .qpi_oe(qpi_oe), .rx_start(rx_start), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_end(rx_end), .tx_en(tx_en), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .err(err)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    logic [8:0] rxq[$];
    int         ends = 0;
    int         spur = 0;
    bit         oe_seen = 1'b0;
    bit         first_pend = 1'b0;
    int         rx_seen = 0;
    int         dec_after = -1;
    int         dec_left = 0;
    logic [7:0] dec_next = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One system clock; decoder model and output monitor run #1 after the edge.
    task automatic tick();
        logic       hs;
        logic [8:0] e;
        hs = tx_valid & tx_ready;
        @(posedge clock);
        #1;
        if (hs) begin
            dec_left--;
            dec_next++;
            if (dec_left > 0) tx_data = dec_next;
            else tx_valid = 1'b0;
        end
        if (qpi_oe) oe_seen = 1'b1;
        if (rx_end) ends++;
        if (rx_valid) begin
            rx_seen++;
            if (rxq.size() == 0) spur++;
            else begin
                e = rxq.pop_front();
                chk("rx_byte", {23'b0, rx_start, rx_data}, {23'b0, e});
            end
            if (rx_seen == dec_after) begin
                tx_en = 1'b1;
                if (dec_left > 0) begin
                    tx_valid = 1'b1;
                    tx_data  = dec_next;
                end
                dec_after = -1;
            end
        end
    endtask

    // Edge at phase start, data for the next edge changes mid-phase, pins sampled at phase end.
    task automatic phase(input logic lvl, input logic [3:0] nxt, output logic [3:0] smp);
        qpi_clk = lvl;
        repeat (4) tick();
        qpi_di = nxt;
        repeat (4) tick();
        smp = qpi_do;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] nxt_hi, input bit push);
        logic [3:0] s;
        if (push) begin
            rxq.push_back({first_pend, b});
            first_pend = 1'b0;
        end
        phase(1'b0, b[3:0], s);
        phase(1'b1, nxt_hi, s);
    endtask

    task automatic read_byte(output logic [7:0] r);
        logic [3:0] h;
        logic [3:0] l;
        rxq.push_back({first_pend, 8'h00});
        first_pend = 1'b0;
        phase(1'b0, 4'h0, h);
        phase(1'b1, 4'h0, l);
        r = {h, l};
    endtask

    task automatic csb_low(input logic [3:0] hi);
        qpi_di     = hi;
        qpi_csb    = 1'b0;
        rx_seen    = 0;
        first_pend = 1'b1;
        repeat (8) tick();
    endtask

    task automatic csb_high();
        qpi_csb = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        logic [7:0] wr[15];
        logic [7:0] r;
        logic [3:0] s;
        int         e0;

        // Reset state
        repeat (4) tick();
        chk("rst_rx_valid", {31'b0, rx_valid}, 0);
        chk("rst_rx_start", {31'b0, rx_start}, 0);
        chk("rst_rx_end", {31'b0, rx_end}, 0);
        chk("rst_rx_data", {24'b0, rx_data}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_oe", {31'b0, qpi_oe}, 0);
        chk("rst_do", {28'b0, qpi_do}, 0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 1);
        reset = 1'b0;
        repeat (4) tick();

        // Write transaction: 21 01 10 01..0C
        wr[0] = OP_WRITE; wr[1] = 8'h01; wr[2] = 8'h10;
        for (int i = 0; i < 12; i++) wr[3+i] = 8'(i + 1);
        e0 = ends; oe_seen = 1'b0;
        csb_low(wr[0][7:4]);
        for (int i = 0; i < 15; i++) send_byte(wr[i], (i < 14) ? wr[(i+1)%15][7:4] : 4'h0, 1'b1);
        csb_high();
        chk("wr_rx_pending", rxq.size(), 0);
        chk("wr_rx_end_count", ends - e0, 1);
        chk("wr_err", {31'b0, err}, 0);
        chk("wr_oe_seen", {31'b0, oe_seen}, 0);

        // Read transaction: 22 03 10, decoder supplies A0 A1 A2
        dec_after = 3; dec_left = 3; dec_next = 8'hA0;
        csb_low(4'h2);
        send_byte(OP_READ, 4'h0, 1'b1);
        send_byte(8'h03, 4'h1, 1'b1);
        send_byte(8'h10, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            read_byte(r);
            chk("rd_byte", {24'b0, r}, 32'(8'hA0 + k));
        end
        qpi_csb = 1'b1;
        tick();
        chk("rd_oe_before_sync", {31'b0, qpi_oe}, 1);
        repeat (7) tick();
        chk("rd_oe_after_csb", {31'b0, qpi_oe}, 0);
        chk("rd_decoder_drained", dec_left, 0);
        chk("rd_err", {31'b0, err}, 0);
        chk("rd_rx_pending", rxq.size(), 0);
        tx_en = 1'b0;

        // Underflow: tx_valid held low for two read bytes
        dec_after = 3; dec_left = 0;
        csb_low(4'h2);
        send_byte(OP_READ, 4'h0, 1'b1);
        send_byte(8'h02, 4'h1, 1'b1);
        send_byte(8'h10, 4'h0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            read_byte(r);
            chk("uf_byte", {24'b0, r}, 32'hFF);
        end
        csb_high();
        chk("uf_err_set", {31'b0, err}, 1);
        tx_en = 1'b0;

        // Odd nibble end: 0x21 then a lone high nibble 0x3
        e0 = ends;
        csb_low(4'h2);
        chk("odd_err_cleared", {31'b0, err}, 0);
        send_byte(OP_WRITE, 4'h3, 1'b1);
        phase(1'b0, 4'h0, s);
        csb_high();
        chk("odd_err_set", {31'b0, err}, 1);
        chk("odd_rx_end_count", ends - e0, 1);
        chk("odd_rx_pending", rxq.size(), 0);
        chk("odd_spurious", spur, 0);
        qpi_clk = 1'b1;
        repeat (4) tick();

        // Reset mid-write: two bytes, reset, three more bytes that must be discarded
        csb_low(4'h2);
        send_byte(OP_WRITE, 4'h0, 1'b1);
        send_byte(8'h01, 4'h1, 1'b1);
        reset = 1'b1;
        repeat (3) tick();
        chk("mid_rst_err", {31'b0, err}, 0);
        chk("mid_rst_tx_ready", {31'b0, tx_ready}, 1);
        reset = 1'b0;
        send_byte(8'h10, 4'h0, 1'b0);
        send_byte(8'h01, 4'h0, 1'b0);
        send_byte(8'h02, 4'h0, 1'b0);
        csb_high();
        chk("mid_rst_spurious", spur, 0);
        chk("mid_rst_rx_pending", rxq.size(), 0);
        csb_low(4'h2);
        send_byte(OP_WRITE, 4'h5, 1'b1);
        send_byte(8'h5A, 4'h0, 1'b1);
        csb_high();
        chk("post_rst_rx_pending", rxq.size(), 0);

        // Boundary: clk idling low at csb fall, first rising edge ignored
        qpi_clk = 1'b0;
        repeat (4) tick();
        csb_low(4'h2);
        phase(1'b1, 4'h2, s);
        send_byte(OP_WRITE, 4'h5, 1'b1);
        send_byte(8'h5A, 4'h0, 1'b1);
        csb_high();
        chk("bnd_low_rx_pending", rxq.size(), 0);

        // Boundary: csb fall coincident with a falling clk edge carrying a junk nibble
        qpi_di = 4'hF;
        repeat (4) tick();
        qpi_csb = 1'b0;
        qpi_clk = 1'b0;
        rx_seen = 0;
        first_pend = 1'b1;
        repeat (4) tick();
        phase(1'b1, 4'h2, s);
        send_byte(OP_WRITE, 4'hC, 1'b1);
        send_byte(8'hC3, 4'h0, 1'b1);
        csb_high();
        chk("bnd_coinc_rx_pending", rxq.size(), 0);
        chk("final_spurious", spur, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
